// File: rtl/rijndael_inv_keyschedule.sv
// rijndael_inv_keyschedule: emits Rijndael round keys NR..0 for decryption by
// forward-expanding the cipher key, then running the schedule backwards.
module rijndael_inv_keyschedule #(
  parameter int NB = 4,
  parameter int NK = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [32*NK-1:0] key_i,
  output logic             busy_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [32*NB-1:0] roundkey_o,
  output logic [3:0]       rnd_o
);
  localparam int NR = (NB > NK ? NB : NK) + 6;
  localparam int T = NB * (NR + 1);
  localparam logic [6:0] LAST = 7'(T - 1);
  localparam logic [6:0] SNAP = 7'(T - NK);
  localparam logic [6:0] NB7 = 7'(NB);
  localparam logic [7:0] NK8 = 8'(NK);

  typedef enum logic [1:0] {IDLE, FWD, REV} state_t;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = '0;
    t = a;
    for (int k = 0; k < 8; k++) begin
      p = b[k] ? p ^ t : p;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v, t;
    v = 8'h01;
    t = x;
    for (int k = 1; k < 8; k++) begin
      t = gmul(t, t);
      v = gmul(v, t);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  state_t state;
  logic [31:0] win [NK];
  logic [6:0] idx;
  logic [7:0] rc, xt, ixt, gi;
  logic [32*NB-1:0] col;
  logic [3:0] col_rnd;
  logic full, done, rot, sub4, snap, ship, emit_en;
  logic [31:0] gx, sin, sw, gout, emit;

  // one g() serves both directions; in REV it evaluates g(W[j+NK-1], j+NK)
  always_comb begin
    gx = state == FWD ? win[NK-1] : win[NK-2];
    gi = state == FWD ? {1'b0, idx} : {1'b0, idx} + NK8;
    rot = gi % NK8 == 8'd0;
    sub4 = NK == 8 && gi % NK8 == 8'd4;
    sin = rot ? {gx[23:0], gx[31:24]} : gx;
    sw = {sbox(sin[31:24]), sbox(sin[23:16]), sbox(sin[15:8]), sbox(sin[7:0])};
    gout = rot ? sw ^ {rc, 24'h0} : sub4 ? sw : gx;
    snap = idx >= SNAP;
    emit = win[NK-1] ^ (snap ? 32'h0 : gout);
    xt = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
    ixt = rc[0] ? ((rc ^ 8'h1b) >> 1) | 8'h80 : rc >> 1;
    ship = full && (!valid_o || ready_i);
    emit_en = state == REV && !done && (!full || ship);
  end

  // REV rotates the window: the snapshot words wrap around untouched, after
  // which each recovered word enters at the bottom
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      idx <= '0;
      rc <= 8'h01;
      col <= '0;
      col_rnd <= '0;
      full <= 1'b0;
      done <= 1'b0;
      busy_o <= 1'b0;
      valid_o <= 1'b0;
      roundkey_o <= '0;
      rnd_o <= '0;
      for (int k = 0; k < NK; k++) win[k] <= '0;
    end else begin
      if (state == IDLE && start_i) begin
        state <= FWD;
        busy_o <= 1'b1;
        idx <= 7'(NK);
        rc <= 8'h01;
        full <= 1'b0;
        done <= 1'b0;
        for (int k = 0; k < NK; k++) win[k] <= key_i[32*(NK-1-k) +: 32];
      end
      if (state == FWD) begin
        for (int k = 0; k < NK - 1; k++) win[k] <= win[k+1];
        win[NK-1] <= win[0] ^ gout;
        if (rot && idx < SNAP) rc <= xt;
        if (idx == LAST) state <= REV;
        else idx <= idx + 7'd1;
      end
      if (ship) begin
        valid_o <= 1'b1;
        roundkey_o <= col;
        rnd_o <= col_rnd;
        full <= 1'b0;
      end else if (ready_i) valid_o <= 1'b0;
      if (emit_en) begin
        win[0] <= emit;
        for (int k = 1; k < NK; k++) win[k] <= win[k-1];
        col <= {emit, col[32*NB-1:32]};
        if (!snap && rot) rc <= ixt;
        if (idx == 7'd0) done <= 1'b1;
        else idx <= idx - 7'd1;
        if (idx % NB7 == 7'd0) begin
          full <= 1'b1;
          col_rnd <= 4'(idx / NB7);
        end
      end
      if (valid_o && ready_i && rnd_o == 4'd0) begin
        state <= IDLE;
        busy_o <= 1'b0;
      end
    end
  end
endmodule
